tinyalu_requester: RTL

- Initiator end of the TinyALU start/done command protocol.
- Accepts commands on a valid/ready interface, drives op, A and B, and holds start until done arrives. Captures the 16-bit result and presents it on a valid/ready response interface.
- Sits between a testbench or sequencer and the ALU. Its output must always satisfy the protocol firewall assertions:
  - op, A and B are stable from start until done.
  - start deasserts the cycle after done.
  - No done without start.

---
 rtl/tinyalu_requester.sv | 112 +++++++++++
 1 files changed

// File: rtl/tinyalu_requester.sv
// Initiator side of the TinyALU start/done protocol: command valid/ready in, response valid/ready out.
// Optional ACTIVE-state timeout abort is enabled by defining TINYALU_REQ_TIMEOUT_EN.
module tinyalu_requester #(
   parameter int unsigned TIMEOUT = 15,
   parameter int unsigned CNT_W   = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [2:0]  cmd_op,
   input  logic [7:0]  cmd_a,
   input  logic [7:0]  cmd_b,
   output logic        start,
   output logic [2:0]  op,
   output logic [7:0]  A,
   output logic [7:0]  B,
   input  logic        done,
   input  logic [15:0] result,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_result,
   output logic        rsp_err,
   output logic        proto_err
);

   typedef enum logic [1:0] {IDLE, NOP, ACTIVE, GAP} state_t;

   state_t state, state_nxt;
   logic   accept;
   logic   finish;
   logic   tmo;

   if (TIMEOUT < 4 || (64'd1 << CNT_W) <= 64'(TIMEOUT)) begin : g_bad_cfg
      $error("tinyalu_requester: TIMEOUT must be >= 4 and below 2**CNT_W");
   end

   // start is decoded from registered state so a reset drops it immediately.
   assign start     = (state == NOP) || (state == ACTIVE);
   assign cmd_ready = (state == IDLE) && !rsp_valid;
   assign accept    = cmd_valid && cmd_ready;
   assign finish    = (state == ACTIVE) && done;

`ifdef TINYALU_REQ_TIMEOUT_EN
   logic [CNT_W-1:0] cnt;
   logic             rsp_err_q;

   // Count equals the number of completed ACTIVE cycles; the abort happens on the TIMEOUT-th.
   assign tmo     = (state == ACTIVE) && !done && (cnt == CNT_W'(TIMEOUT - 1));
   assign rsp_err = rsp_err_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt       <= '0;
         rsp_err_q <= 1'b0;
      end else begin
         if (state != ACTIVE) cnt <= '0;
         else if (!done)      cnt <= cnt + 1'b1;
         if (finish)          rsp_err_q <= 1'b0;
         else if (tmo)        rsp_err_q <= 1'b1;
      end
   end
`else
   assign tmo     = 1'b0;
   assign rsp_err = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (accept) state_nxt = (cmd_op == 3'd0) ? NOP : ACTIVE;
         NOP:     state_nxt = GAP;
         ACTIVE:  if (finish || tmo) state_nxt = GAP;
         GAP:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op         <= '0;
         A          <= '0;
         B          <= '0;
         rsp_valid  <= 1'b0;
         rsp_result <= '0;
         proto_err  <= 1'b0;
      end else begin
         if (accept) begin
            op <= cmd_op;
            A  <= cmd_a;
            B  <= cmd_b;
         end
         // done wins over a same-cycle timeout because tmo already requires !done.
         if (finish) begin
            rsp_valid  <= 1'b1;
            rsp_result <= result;
         end else if (tmo) begin
            rsp_valid  <= 1'b1;
            rsp_result <= '0;
         end else if (rsp_valid && rsp_ready) begin
            rsp_valid  <= 1'b0;
         end
         if (done && !start) proto_err <= 1'b1;
      end
   end

endmodule
